// File: rtl/sm3_madd_pkg.sv
// Shared types and elaboration helpers for the SM3 multi-operand modular adder.
package sm3_madd_pkg;

  localparam int unsigned MAX_WIDTH  = 64;
  localparam int unsigned MAX_NUM_IN = 6;
  localparam int unsigned MAX_TAG_W  = 16;
  localparam int unsigned DEF_NUM_IN = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned CW     = clog2(DEF_NUM_IN);
  localparam int unsigned MAX_CW = clog2(MAX_NUM_IN);
  localparam int unsigned MAX_VW = MAX_WIDTH + MAX_CW;

  // One 3:2 row removes one vector, so reaching two vectors takes num_in-2 rows.
  function automatic int unsigned csa_levels(input int unsigned num_in);
    return (num_in > 2) ? num_in - 2 : 0;
  endfunction

  // Sized for the widest legal configuration; narrower instances use the low bits.
  typedef struct packed {
    logic [MAX_VW-1:0]    sum_v;
    logic [MAX_VW-1:0]    carry_v;
    logic [MAX_TAG_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/sm3_csa_row.sv
// Single 3:2 carry-save compressor row; the carry out of the top bit is dropped.
module sm3_csa_row
  import sm3_madd_pkg::*;
#(
  parameter int unsigned W = 34
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/sm3_madd_pipe.sv
// Pipelined NUM_IN-operand adder mod 2^WIDTH with carry-out report and valid/ready flow.
module sm3_madd_pipe
  import sm3_madd_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned USE_CSA = 1,
  parameter int unsigned PIPE    = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_IN*WIDTH-1:0]    in_ops,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic [clog2(NUM_IN)-1:0]   out_carry,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       busy
);

  localparam int unsigned CWN  = clog2(NUM_IN);
  localparam int unsigned XW   = WIDTH + CWN;
  localparam int unsigned ROWS = csa_levels(NUM_IN);

  logic [XW-1:0]    opx [NUM_IN];
  logic [XW-1:0]    red_s, red_c;
  logic [XW-1:0]    cpa_s, cpa_c, exact;
  logic [TAG_W-1:0] cpa_tag;
  logic [PIPE-1:0]  v, rdy, ld;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ext
    assign opx[i] = XW'(in_ops[i*WIDTH +: WIDTH]);
  end

  // Reduce the operands to two vectors whose sum is the exact result.
  if (NUM_IN == 2) begin : g_red2
    assign red_s = opx[0];
    assign red_c = opx[1];
  end else if (USE_CSA != 0) begin : g_csa
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [XW-1:0] s_i, c_i, s_o, c_o;
      if (r == 0) begin : g_src
        assign s_i = opx[0];
        assign c_i = opx[1];
      end else begin : g_src
        assign s_i = g_row[r-1].s_o;
        assign c_i = g_row[r-1].c_o;
      end
      sm3_csa_row #(.W(XW)) u_row (
        .a     (s_i),
        .b     (c_i),
        .c     (opx[r+2]),
        .sum   (s_o),
        .carry (c_o)
      );
    end
    assign red_s = g_row[ROWS-1].s_o;
    assign red_c = g_row[ROWS-1].c_o;
  end else begin : g_chain
    // The last operand is left for the final add, giving NUM_IN-1 adds in total.
    for (genvar i = 1; i < NUM_IN - 1; i++) begin : g_add
      logic [XW-1:0] acc;
      if (i == 1) begin : g_src
        assign acc = opx[0] + opx[1];
      end else begin : g_src
        assign acc = g_add[i-1].acc + opx[i];
      end
    end
    assign red_s = g_add[NUM_IN-2].acc;
    assign red_c = opx[NUM_IN-1];
  end

  // Per-stage valid and ready: a stage can load unless it and every later stage are full.
  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    logic v_q, vin;
    if (k == 0) begin : g_src
      assign vin = in_valid;
    end else begin : g_src
      assign vin = v[k-1];
    end
    assign rdy[k] = out_ready | ~(&v[PIPE-1:k]);
    assign ld[k]  = vin & rdy[k] & ~flush;
    always_ff @(posedge clk) begin
      if (rst)         v_q <= 1'b0;
      else if (flush)  v_q <= 1'b0;
      else if (rdy[k]) v_q <= vin;
    end
    assign v[k] = v_q;
  end

  if (PIPE == 2) begin : g_red_reg
    stage_t st_q;
    logic   unused_st;
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q <= '0;
      end else if (ld[0]) begin
        st_q.sum_v   <= MAX_VW'(red_s);
        st_q.carry_v <= MAX_VW'(red_c);
        st_q.tag     <= MAX_TAG_W'(in_tag);
      end
    end
    assign cpa_s     = XW'(st_q.sum_v);
    assign cpa_c     = XW'(st_q.carry_v);
    assign cpa_tag   = TAG_W'(st_q.tag);
    assign unused_st = ^{st_q.sum_v, st_q.carry_v, st_q.tag};
  end else begin : g_red_comb
    assign cpa_s   = red_s;
    assign cpa_c   = red_c;
    assign cpa_tag = in_tag;
  end

  assign exact = cpa_s + cpa_c;

  // Output register: low bits are the modular sum, the rest the discarded carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= '0;
      out_carry <= '0;
      out_tag   <= '0;
    end else if (ld[PIPE-1]) begin
      out_sum   <= exact[WIDTH-1:0];
      out_carry <= exact[XW-1:WIDTH];
      out_tag   <= cpa_tag;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[PIPE-1];
  assign busy      = |v;

endmodule

// File: doc/sm3_madd_pipe.md
# sm3_madd_pipe

Parametrised, pipelined multi-operand modular adder for the SM3 compression datapath. It is the successor to the fixed 3-input, 32-bit combinational adder. It sums NUM_IN operands modulo 2^WIDTH and also reports the discarded high carry bits. Operands are reduced through a carry-save tree, then resolved by a final carry-propagate adder, with registered stages and valid/ready flow control. It feeds the TT1/TT2 and SS1 terms of the round logic, and can be reused for any wider or deeper sum.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits (8..64).
- NUM_IN, 4, number of operands (2..6).
- USE_CSA, 1: 1 = carry-save reduction tree, then one carry-propagate add. 0 = chain of NUM_IN-1 two-input adds.
- PIPE, 2, number of register stages (1 or 2). 1 = output register only. 2 = register after reduction, plus output register.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts an operand set this cycle.
- in_ops  in  NUM_IN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- flush  in  1  synchronous discard of all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum of all operands mod 2^WIDTH.
- out_carry  out  CW  bits [WIDTH +: CW] of the exact sum, where CW = $clog2(NUM_IN).
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  at least one stage holds a valid entry.

## Operation
- Exact sum width is WIDTH+CW bits. out_sum is its low WIDTH bits; out_carry is the rest. Unsigned arithmetic only.
- USE_CSA=1: 3:2 compressor rows reduce NUM_IN vectors to two vectors of width WIDTH+CW. A carry-propagate add then produces the exact sum. USE_CSA=0 produces an identical result through a different structure.
- Each stage k holds a valid bit v[k] and a payload.
- A stage is stalled when v[k]=1 and the next stage (or the consumer, for the last stage) does not accept.
- Rule: a stage loads when it is empty or its contents move on this cycle. This gives a ready chain ready[k] = !v[k] | ready[k+1], with ready[last+1] = out_ready.
- in_ready = ready[0]. This is combinational from out_ready; no other combinational input-to-output path is allowed.
- An input transfer is in_valid & in_ready. An output transfer is out_valid & out_ready.
- Payload registers load only on transfer. Held outputs stay stable while stalled.
- flush: all v[k] clear at the next edge. An input transfer in the same cycle is also discarded. in_ready is unaffected by flush.
- Results leave in input order; there is no reordering.

## Timing
- Reset values: out_valid=0, busy=0, and all v[k]=0. out_sum, out_carry and out_tag are 0. in_ready is 1 from the first cycle after reset is released.
- rst asserted mid-operation discards all in-flight data at that edge. rst has priority over flush and over transfers.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+PIPE-1 and is visible during cycle N+PIPE. For PIPE=2, accept in cycle 0 gives the result in cycle 2.
- Throughput: one operation per cycle while out_ready=1.
- Stall: with out_ready=0, the pipe fills to PIPE entries. in_ready then drops in the cycle after the last free stage fills.
- Release: when out_ready rises, every stage advances in that same cycle, and in_ready=1 in that same cycle.
- Simultaneous accept and drain on a full pipe is legal and loses no entry.
- busy = OR of all v[k].

## Structure
- Package sm3_madd_pkg holds:
  - function clog2 and localparam CW.
  - function csa_levels(NUM_IN), the number of 3:2 rows.
  - Stage payload struct: sum vector, carry vector, tag.
- One sub-module, sm3_csa_row: a single 3:2 compressor row, parametrised by width. It is instantiated csa_levels times in a generate loop.
- Handshake and valid logic is identical for every stage and is generated per stage.

## Test plan
- Basic: NUM_IN=4, WIDTH=32, operands 0x00000001, 0x00000002, 0x00000003, 0x00000004, tag 0x5 → out_sum 0x0000000A, out_carry 0, out_tag 0x5, two cycles after accept (PIPE=2).
- Wrap: NUM_IN=4, all operands 0xFFFFFFFF → out_sum 0xFFFFFFFC, out_carry 3. NUM_IN=3, operands 0x80000000 ×3 → out_sum 0x80000000, out_carry 1.
- Streaming: 16 back-to-back random sets with out_ready=1 → 16 results in order, one per cycle, matching the reference model for USE_CSA=0 and USE_CSA=1.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 → exactly PIPE operations accepted and in_ready=0 afterwards. Raise out_ready → no loss and no duplicates, order preserved.
- Flush: two operations in flight, assert flush with in_valid=1 → next cycle out_valid=0 and busy=0, and the flushed-cycle input never appears at the output.
- Reset mid-stream: assert rst for one cycle with the pipe full → next cycle out_valid=0, out_sum=0, busy=0, in_ready=1. The first post-reset operation returns the correct sum.
